// File: rtl/led_ctrl_pkg.sv
// Shared types, default constants and small helpers for the LED control stage.
package led_ctrl_pkg;

    // Debounce FSM states: released, checking a press, pressed, checking a release.
    typedef enum logic [1:0] {
        REL       = 2'd0,
        PRESS_CHK = 2'd1,
        PRS       = 2'd2,
        REL_CHK   = 2'd3
    } db_state_e;

    // Width of the LED selector output.
    localparam int LED_SEL_W = 2;

    // Board clock and debounce window used to derive the default cycle counts.
    localparam int CLK_HZ = 50_000_000;
    localparam int DB_MS  = 20;

    // One toggle period of one second and a 20 ms debounce window.
    localparam int DEF_TICK_CYCLES = CLK_HZ;
    localparam int DEF_DB_CYCLES   = (CLK_HZ / 1000) * DB_MS;

    // Counter width for a counter that spans 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    // Advance the LED selector, wrapping to zero after the last LED.
    // The >= also pulls any out-of-range value straight back to LED 0.
    function automatic logic [LED_SEL_W-1:0] sel_advance(
        input logic [LED_SEL_W-1:0] cur,
        input logic [LED_SEL_W-1:0] max_idx
    );
        logic [LED_SEL_W-1:0] nxt;
        if (cur >= max_idx) begin
            nxt = '0;
        end else begin
            nxt = cur + LED_SEL_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/led_ctrl_key_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM for an active-low key.
// press_evt pulses for exactly one cycle per accepted press; releases are silent.
module key_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int            CW     = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          key_s_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;

    // Bring the asynchronous key into the clk domain; both flops idle at released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            key_s_q <= sync1_q;
        end
    end

    // Debounce FSM: a level change is accepted only after the counter has seen
    // DB_CYCLES consecutive qualifying samples; any contrary sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REL;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                REL: begin
                    if (!key_s_q) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (key_s_q) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                PRS: begin
                    if (key_s_q) begin
                        state_q <= REL_CHK;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                    end
                end
                REL_CHK: begin
                    if (!key_s_q) begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_MAX) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= REL_CHK;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The event is decoded from FSM state so it lines up with the PRESS_CHK->PRS
    // edge; the consumer registers it, keeping the press latency at 2+DB+1.
    assign press_evt = (state_q == PRESS_CHK) && !key_s_q && (cnt_q == DB_MAX);

endmodule

// File: rtl/led_ctrl.sv
// LED control stage: 1 s toggle strobe, reload strobe and LED selector,
// driven by one debounced push key. All outputs are registered.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int NUM_LED     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_n,
    output logic                 delay_1s,
    output logic                 load_en,
    output logic [LED_SEL_W-1:0] led_sel
);

    localparam int                   TICK_W   = cnt_width(TICK_CYCLES);
    localparam logic [TICK_W-1:0]    TICK_MAX = TICK_W'(TICK_CYCLES - 1);
    localparam logic [LED_SEL_W-1:0] SEL_MAX  = LED_SEL_W'(NUM_LED - 1);

    logic                 press_evt_s;
    logic                 tick_wrap_s;

    logic [TICK_W-1:0]    tick_cnt_q;
    logic [TICK_W-1:0]    tick_cnt_d;
    logic                 delay_1s_q;
    logic                 delay_1s_d;
    logic                 load_en_q;
    logic                 load_en_d;
    logic [LED_SEL_W-1:0] led_sel_q;
    logic [LED_SEL_W-1:0] led_sel_d;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .press_evt (press_evt_s)
    );

    assign tick_wrap_s = (tick_cnt_q == TICK_MAX);

    // Next-state: a press restarts the period and advances the selector, and
    // beats a coinciding tick wrap so the two strobes never overlap.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        delay_1s_d = 1'b0;
        load_en_d  = 1'b0;
        led_sel_d  = led_sel_q;
        if (press_evt_s) begin
            tick_cnt_d = '0;
            delay_1s_d = 1'b0;
            load_en_d  = 1'b1;
            led_sel_d  = sel_advance(led_sel_q, SEL_MAX);
        end else if (tick_wrap_s) begin
            tick_cnt_d = '0;
            delay_1s_d = 1'b1;
            load_en_d  = 1'b0;
            led_sel_d  = led_sel_q;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
            delay_1s_d = 1'b0;
            load_en_d  = 1'b0;
            led_sel_d  = led_sel_q;
        end
    end

    // State and output registers; reset clears every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            delay_1s_q <= 1'b0;
            load_en_q  <= 1'b0;
            led_sel_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            delay_1s_q <= delay_1s_d;
            load_en_q  <= load_en_d;
            led_sel_q  <= led_sel_d;
        end
    end

    assign delay_1s = delay_1s_q;
    assign load_en  = load_en_q;
    assign led_sel  = led_sel_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl with short periods. A cycle model predicts
// {delay_1s, load_en, led_sel} when each input is driven; the prediction is
// queued and compared after the following clock edge.
module tb_led_ctrl;

    localparam int TICK = 10;
    localparam int DB   = 4;
    localparam int NLED = 3;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic       delay_1s;
    logic       load_en;
    logic [1:0] led_sel;

    int n_tests;
    int n_fail;

    logic [3:0] exp_q[$];

    // Reference model state
    logic m_s1;
    logic m_s2;
    logic m_level;
    int   m_run;
    int   m_age;
    int   m_sel;

    led_ctrl #(
        .TICK_CYCLES (TICK),
        .DB_CYCLES   (DB),
        .NUM_LED     (NLED)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .delay_1s (delay_1s),
        .load_en  (load_en),
        .led_sel  (led_sel)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = 1'b1;
        m_s2    = 1'b1;
        m_level = 1'b1;
        m_run   = 0;
        m_age   = 0;
        m_sel   = 0;
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic key, input logic rst);
        logic       evt;
        logic       e_dly;
        logic       e_load;
        logic [3:0] e;
        logic [3:0] got;
        int         sel_ok;
        @(negedge clk);
        key_n = key;
        rst_n = rst;
        if (!rst) begin
            model_reset();
            e = 4'd0;
        end else begin
            // Debounce: a new level needs DB+1 consecutive samples of key_s.
            evt = 1'b0;
            if (m_s2 != m_level) begin
                if (m_run == DB) begin
                    m_level = m_s2;
                    m_run   = 0;
                    evt     = (m_s2 == 1'b0);
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = key;
            if (evt) begin
                m_sel  = (m_sel + 1) % NLED;
                m_age  = 0;
                e_dly  = 1'b0;
                e_load = 1'b1;
            end else begin
                e_load = 1'b0;
                m_age++;
                if (m_age == TICK) begin
                    e_dly = 1'b1;
                    m_age = 0;
                end else begin
                    e_dly = 1'b0;
                end
            end
            e = {e_dly, e_load, 2'(m_sel)};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {delay_1s, load_en, led_sel};
        chk("sb", 32'(got), 32'(exp_q.pop_front()));
        chk("inv_excl", 32'(delay_1s & load_en), 32'd0);
        sel_ok = (int'(led_sel) < NLED) ? 1 : 0;
        chk("inv_sel", 32'(sel_ok), 32'd1);
    endtask

    task automatic do_reset(input logic key);
        for (int i = 0; i < 3; i++) begin
            step(key, 1'b0);
            chk("rst_out", 32'({delay_1s, load_en, led_sel}), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        int lat;
        int exp_seq[3];
        logic k;
        n_tests = 0;
        n_fail  = 0;
        exp_seq = '{1, 2, 0};
        rst_n   = 1'b0;
        key_n   = 1'b1;
        model_reset();

        // A: idle key, tick cadence from reset release
        do_reset(1'b1);
        for (int c = 1; c <= 30; c++) begin
            step(1'b1, 1'b1);
            chk("A_dly", 32'(delay_1s), 32'((c % TICK) == 0));
            chk("A_load", 32'(load_en), 32'd0);
            chk("A_sel", 32'(led_sel), 32'd0);
        end

        // B: clean press from cycle 3; press coincides with tick wrap at cycle 10
        do_reset(1'b1);
        for (int c = 1; c <= 40; c++) begin
            k = (c >= 4 && c <= 23) ? 1'b0 : 1'b1;
            step(k, 1'b1);
            chk("B_load", 32'(load_en), 32'(c == 10));
            chk("B_dly", 32'(delay_1s), 32'(c == 20 || c == 30 || c == 40));
            chk("B_sel", 32'(led_sel), (c >= 10) ? 32'd1 : 32'd0);
        end

        // C: bouncing key is rejected, cadence unaffected
        do_reset(1'b1);
        for (int c = 1; c <= 30; c++) begin
            k = (c <= 12) ? 1'(((c - 1) / 2) % 2) : 1'b1;
            step(k, 1'b1);
            chk("C_load", 32'(load_en), 32'd0);
            chk("C_sel", 32'(led_sel), 32'd0);
            chk("C_dly", 32'(delay_1s), 32'((c % TICK) == 0));
        end

        // D: three clean presses, selector walks 1, 2, 0
        do_reset(1'b1);
        pulses = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 24; c++) begin
                step((c < 10) ? 1'b0 : 1'b1, 1'b1);
                if (load_en) begin
                    if (pulses < 3) begin
                        chk("D_sel", 32'(led_sel), 32'(exp_seq[pulses]));
                    end else begin
                        chk("D_extra", 32'(pulses + 1), 32'd3);
                    end
                    pulses++;
                end
            end
        end
        chk("D_cnt", 32'(pulses), 32'd3);

        // E: reset during press qualification, then full re-qualification
        do_reset(1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int c = 3; c <= 7; c++) begin
            step(1'b0, 1'b1);
            chk("E_pre_load", 32'(load_en), 32'd0);
        end
        do_reset(1'b0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 1'b1);
            if (load_en && lat < 0) begin
                lat = c;
            end
            if (lat < 0) begin
                chk("E_dly_quiet", 32'(delay_1s), 32'd0);
            end
        end
        chk("E_lat", 32'(lat), 32'd7);
        chk("E_sel", 32'(led_sel), 32'd1);
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Control stage directly upstream of the LED toggle block.
- Produces the three signals that block consumes: the 1 s toggle strobe (delay_1s), the reload strobe (load_en), and the LED selector (led_sel).
- Debounces one active-low push key. Each press advances led_sel and restarts the 1 s period.

Parameters:
TICK_CYCLES, 50_000_000, clk cycles per delay_1s period (1 s at 50 MHz); must be >= 2
DB_CYCLES, 1_000_000, consecutive stable key samples required to accept a level change (20 ms at 50 MHz); must be >= 1
NUM_LED, 3, number of selectable LEDs; led_sel counts 0..NUM_LED-1; legal range 1..4

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_n  input  1  raw push key, active-low, asynchronous to clk, bouncy
delay_1s  output  1  one-cycle strobe once per TICK_CYCLES cycles
load_en  output  1  one-cycle strobe on accepted key press
led_sel  output  2  index of the LED currently toggled by delay_1s

Behaviour:
- Reset is asynchronous and active-low on rst_n. All state is clocked on posedge clk.
- Reset values:
  - delay_1s=0, load_en=0, led_sel=2'd0, tick counter=0
  - both key synchronizer flops=1 (key released)
  - debounce FSM=REL, debounce counter=0
- Synchronizer: key_n passes through 2 flops. Only the second flop output (key_s) is used.
- Debounce FSM states: REL, PRESS_CHK, PRS, REL_CHK.
  - REL: key_s=0 -> PRESS_CHK, counter cleared.
  - PRESS_CHK: key_s=1 -> REL, counter cleared. Else counter increments. On the cycle where counter reaches DB_CYCLES-1 with key_s=0 -> PRS, and press_evt is 1 for that single cycle.
  - PRS: key_s=1 -> REL_CHK, counter cleared.
  - REL_CHK: key_s=0 -> PRS, counter cleared. Else counter increments. Counter reaching DB_CYCLES-1 with key_s=1 -> REL. No event is generated on release.
  - A held key generates exactly one press_evt; there is no auto-repeat.
- Tick counter: counts 0..TICK_CYCLES-1.
  - On the edge where counter==TICK_CYCLES-1: counter<=0 and delay_1s<=1.
  - Otherwise: counter<=counter+1 and delay_1s<=0.
  - The first delay_1s rises TICK_CYCLES cycles after reset deassertion. Pulses then repeat every TICK_CYCLES cycles.
- On press_evt (single edge, all registered):
  - load_en<=1 for exactly one cycle.
  - led_sel<=led_sel+1, wrapping from NUM_LED-1 to 0.
  - tick counter<=0.
  - delay_1s<=0.
- Simultaneous press_evt and tick wrap: the press wins. delay_1s stays 0, load_en=1, counter=0. The next delay_1s comes TICK_CYCLES cycles later.
- Invariants:
  - load_en and delay_1s are never 1 in the same cycle.
  - led_sel never reaches NUM_LED or above.
  - led_sel changes only in the cycle load_en is 1.
- Press-to-output latency: load_en rises 2 (synchronizer) + DB_CYCLES + 1 cycles after key_n falls, given a clean edge.
- Reset mid-operation (counting or debouncing): everything returns to reset values immediately. No strobe is emitted during or on exit from reset.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. Comparisons are done at full width, with no truncation.

Decomposition:
- Package led_ctrl_pkg:
  - debounce state enum (REL, PRESS_CHK, PRS, REL_CHK)
  - LED_SEL_W=2
  - default constants CLK_HZ=50_000_000 and DB_MS=20, used to derive TICK_CYCLES/DB_CYCLES
- Sub-module key_debounce (param DB_CYCLES):
  - contains the synchronizer and debounce FSM
  - ports clk, rst_n, key_n, press_evt
- led_ctrl keeps the tick counter, selector, and strobe registers.

Test Plan (bench overrides TICK_CYCLES=10, DB_CYCLES=4, NUM_LED=3):
- Reset release, key held high -> delay_1s pulses at cycles 10, 20, 30 after release. load_en stays 0. led_sel stays 0.
- Clean press: key_n low at cycle 3 and held 20 cycles -> exactly one load_en at cycle 3+2+4+1=10. led_sel 0->1 in that cycle. delay_1s 0 at cycle 10. Next delay_1s at cycle 20.
- Bounce: key_n toggles low/high every 2 cycles for 12 cycles, then high -> no load_en, led_sel unchanged, delay_1s cadence unaffected.
- Three clean presses, each separated by 12+ cycles of release -> led_sel 1, 2, 0. One load_en per press.
- Press timed so press_evt coincides with counter==9 -> load_en=1 and delay_1s=0 that cycle. delay_1s next fires 10 cycles later.
- Assert rst_n low mid-debounce (PRESS_CHK, counter=2) for 3 cycles, key still low -> outputs 0/0/0 during and after reset. A press is accepted only after a full 2+4 re-qualification. No spurious strobe.
